// File: rtl/reg_check_monitor.sv
// reg_check_monitor: confirms an ordered list of (register, value) writebacks lands within a cycle budget
module reg_check_monitor #(
    parameter int NUM_CHECKS = 8,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int TIMEOUT_PER_CHECK = 0,
    parameter int STRICT = 0,
    localparam int IW = NUM_CHECKS > 1 ? $clog2(NUM_CHECKS) : 1,
    localparam int CW = $clog2(NUM_CHECKS) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [IW-1:0]             cfg_idx,
    input  logic [REG_ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0]     cfg_data,
    input  logic [CW-1:0]             cfg_count,
    input  logic                      start,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      fail,
    output logic                      timeout,
    output logic [IW-1:0]             fail_idx,
    output logic [DATA_WIDTH-1:0]     fail_data,
    output logic [CW-1:0]             checks_passed
);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, CHECK, PASS, FAIL} state_t;
    state_t state;
    logic [REG_ADDR_WIDTH-1:0] tbl_addr [NUM_CHECKS];
    logic [DATA_WIDTH-1:0] tbl_data [NUM_CHECKS];
    logic [CW-1:0] idx, cnt;
    logic [TW-1:0] timer;
    logic [REG_ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_data;
    logic hit, miss, expire, last;
    assign checks_passed = idx;
    always_comb begin
        cur_addr = tbl_addr[idx[IW-1:0]];
        cur_data = tbl_data[idx[IW-1:0]];
        hit = cur_addr == '0 ? cur_data == '0 : wb_en && wb_addr == cur_addr && wb_data == cur_data;
        miss = STRICT != 0 && cur_addr != '0 && wb_en && wb_addr == cur_addr && wb_data != cur_data;
        expire = timer == TW'(TIMEOUT_CYCLES - 1);
        last = idx == cnt - CW'(1);
    end
    // the table has no reset so a programmed sequence survives an aborted run
    always_ff @(posedge clk)
        if (rst && state == IDLE && cfg_we && int'(cfg_idx) < NUM_CHECKS) begin
            tbl_addr[cfg_idx] <= cfg_addr;
            tbl_data[cfg_idx] <= cfg_data;
        end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            {busy, done, pass, fail, timeout} <= '0;
            fail_idx <= '0;
            fail_data <= '0;
            idx <= '0;
            cnt <= '0;
            timer <= '0;
        end else if (state == CHECK) begin
            if (cnt == '0) begin
                state <= PASS;
                {busy, done, pass} <= 3'b011;
            end else if (hit) begin
                idx <= idx + CW'(1);
                if (TIMEOUT_PER_CHECK != 0)
                    timer <= '0;
                if (last) begin
                    state <= PASS;
                    {busy, done, pass} <= 3'b011;
                end
            end else if (miss || expire) begin
                state <= FAIL;
                {busy, done, fail} <= 3'b011;
                timeout <= !miss;
                fail_idx <= idx[IW-1:0];
                fail_data <= miss ? wb_data : '0;
            end else
                timer <= timer + TW'(1);
        end else if (start) begin
            state <= CHECK;
            {busy, done, pass, fail, timeout} <= 5'b10000;
            fail_idx <= '0;
            fail_data <= '0;
            idx <= '0;
            timer <= '0;
            cnt <= cfg_count > CW'(NUM_CHECKS) ? CW'(NUM_CHECKS) : cfg_count;
        end
    end
endmodule

// File: tb/tb_reg_check_monitor.sv
// tb_reg_check_monitor: four monitor variants (STRICT x TIMEOUT_PER_CHECK) against a list-walking reference model
module tb_reg_check_monitor;
    localparam int N = 8, AW = 5, DW = 32, T = 100;
    logic clk = 0;
    logic rst = 0;
    logic cfg_we = 0;
    logic [2:0] cfg_idx = 0;
    logic [AW-1:0] cfg_addr = 0;
    logic [DW-1:0] cfg_data = 0;
    logic [3:0] cfg_count = 0;
    logic start = 0, wb_en = 0;
    logic [AW-1:0] wb_addr = 0;
    logic [DW-1:0] wb_data = 0;
    logic busy [4], done [4], pass [4], fail [4], timeout [4];
    logic [2:0] fail_idx [4];
    logic [DW-1:0] fail_data [4];
    logic [3:0] checks_passed [4];
    int n_cmp = 0, n_err = 0;
    // reference: status 0 idle, 1 running, 2 passed, 3 failed
    int st [4], pos [4], used [4], cnt [4], fidx [4];
    bit tmo [4];
    logic [DW-1:0] fdat [4];
    logic [AW-1:0] ta [4][N];
    logic [DW-1:0] td [4][N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        reg_check_monitor #(.NUM_CHECKS(N), .REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T),
                            .TIMEOUT_PER_CHECK(g / 2), .STRICT(g % 2)) dut (
            .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
            .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start), .wb_en(wb_en),
            .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy[g]), .done(done[g]), .pass(pass[g]),
            .fail(fail[g]), .timeout(timeout[g]), .fail_idx(fail_idx[g]), .fail_data(fail_data[g]),
            .checks_passed(checks_passed[g])
        );
    end

    task automatic cmp(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit hit;
        for (int k = 0; k < 4; k++) begin
            if (!rst) begin
                st[k] = 0; pos[k] = 0; used[k] = 0; cnt[k] = 0; tmo[k] = 0; fidx[k] = 0; fdat[k] = 0;
            end else if (st[k] == 1) begin
                if (pos[k] == cnt[k]) st[k] = 2;
                else begin
                    a = ta[k][pos[k]];
                    d = td[k][pos[k]];
                    hit = (a == 0) ? (d == 0) : (wb_en && wb_addr == a && wb_data == d);
                    if (hit) begin
                        pos[k]++;
                        if (k / 2 == 1) used[k] = 0;
                        if (pos[k] == cnt[k]) st[k] = 2;
                    end else if (k % 2 == 1 && a != 0 && wb_en && wb_addr == a) begin
                        st[k] = 3; fidx[k] = pos[k]; fdat[k] = wb_data;
                    end else begin
                        used[k]++;
                        if (used[k] == T) begin
                            st[k] = 3; tmo[k] = 1; fidx[k] = pos[k]; fdat[k] = 0;
                        end
                    end
                end
            end else begin
                if (st[k] == 0 && cfg_we) begin
                    ta[k][cfg_idx] = cfg_addr;
                    td[k][cfg_idx] = cfg_data;
                end
                if (start) begin
                    cnt[k] = cfg_count > N ? N : int'(cfg_count);
                    pos[k] = 0; used[k] = 0; tmo[k] = 0; fidx[k] = 0; fdat[k] = 0; st[k] = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            cmp("busy", k, busy[k], st[k] == 1);
            cmp("done", k, done[k], st[k] >= 2);
            cmp("pass", k, pass[k], st[k] == 2);
            cmp("fail", k, fail[k], st[k] == 3);
            cmp("timeout", k, timeout[k], tmo[k]);
            cmp("fail_idx", k, fail_idx[k], fidx[k]);
            cmp("fail_data", k, fail_data[k], fdat[k]);
            cmp("checks_passed", k, checks_passed[k], pos[k]);
        end
    endtask

    task automatic cyc();
        step();
        @(negedge clk);
        check_all();
        cfg_we = 0; start = 0; wb_en = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic prog(input int i, input int a, input int d);
        cfg_we = 1; cfg_idx = 3'(i); cfg_addr = AW'(a); cfg_data = DW'(d);
        cyc();
    endtask

    task automatic wr(input int a, input int d);
        wb_en = 1; wb_addr = AW'(a); wb_data = DW'(d);
        cyc();
    endtask

    task automatic go(input int c);
        cfg_count = 4'(c); start = 1;
        cyc();
    endtask

    task automatic do_reset();
        rst = 0; cyc(); rst = 1;
    endtask

    initial begin
        rst = 0;
        cyc(); cyc();
        cmp("reset_busy", 0, busy[0], 0);
        cmp("reset_done", 0, done[0], 0);
        cmp("reset_checks", 0, checks_passed[0], 0);
        rst = 1;
        prog(0, 1, 5); prog(1, 11, 6); prog(2, 12, 7);
        for (int i = 3; i < N; i++) prog(i, 0, 0);
        // ordered pass with an ignored table write and an ignored start mid-run
        go(3);
        cmp("run_busy", 0, busy[0], 1);
        idle(2); wr(1, 5);
        prog(1, 3, 3);
        cfg_count = 0; start = 1; cyc();
        idle(1); wr(11, 6); idle(2); wr(12, 7);
        cmp("ordered_pass", 0, pass[0], 1);
        cmp("ordered_checks", 0, checks_passed[0], 3);
        cmp("ordered_timeout", 0, timeout[0], 0);
        go(3); idle(2); wr(1, 5); idle(2); wr(11, 6); idle(2); wr(12, 7);
        cmp("rerun_pass", 0, pass[0], 1);
        // wrong value first: tolerant keeps waiting, strict fails
        go(3); idle(1); wr(1, 4);
        cmp("strict_fail", 1, fail[1], 1);
        cmp("strict_fail_idx", 1, fail_idx[1], 0);
        cmp("strict_fail_data", 1, fail_data[1], 4);
        cmp("tolerant_busy", 0, busy[0], 1);
        idle(1); wr(1, 5);
        cmp("tolerant_checks", 0, checks_passed[0], 1);
        cmp("tolerant_checks_tpc", 2, checks_passed[2], 1);
        idle(110);
        // pure timeout: 100 CHECK cycles
        go(1); idle(99);
        cmp("pre_expiry_busy", 0, busy[0], 1);
        cyc();
        cmp("timeout_fail", 0, fail[0], 1);
        cmp("timeout_flag", 0, timeout[0], 1);
        cmp("timeout_idx", 0, fail_idx[0], 0);
        cmp("timeout_data", 0, fail_data[0], 0);
        // match on the expiry cycle wins
        go(1); idle(99); wr(1, 5);
        cmp("expiry_match_pass", 0, pass[0], 1);
        cmp("expiry_match_timeout", 0, timeout[0], 0);
        // empty run
        go(0);
        cmp("empty_busy", 0, busy[0], 1);
        cyc();
        cmp("empty_pass", 0, pass[0], 1);
        cmp("empty_checks", 0, checks_passed[0], 0);
        // count above capacity clamps; trailing (0,0) entries pass on their own
        go(9); wr(1, 5); wr(11, 6); wr(12, 7); idle(6);
        cmp("clamp_pass", 0, pass[0], 1);
        cmp("clamp_checks", 0, checks_passed[0], 8);
        // reset aborts a run; a new run reuses the table
        go(3); idle(3); wr(1, 5);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cmp("abort_busy", k, busy[k], 0);
            cmp("abort_checks", k, checks_passed[k], 0);
        end
        go(3); wr(1, 5); wr(11, 6); wr(12, 7);
        cmp("after_abort_pass", 0, pass[0], 1);
        // per-check budget restart
        do_reset();
        prog(1, 2, 9);
        go(2); idle(79); wr(1, 5);
        idle(40);
        cmp("global_timeout", 0, timeout[0], 1);
        cmp("global_timeout_idx", 0, fail_idx[0], 1);
        cmp("per_check_busy", 2, busy[2], 1);
        idle(59);
        cmp("per_check_still_busy", 2, busy[2], 1);
        cyc();
        cmp("per_check_timeout", 2, timeout[2], 1);
        // x0 writes never match nor mismatch
        do_reset();
        prog(0, 0, 5);
        go(1); wr(0, 5); wr(0, 4); idle(2);
        cmp("x0_no_match", 0, checks_passed[0], 0);
        cmp("x0_no_strict_fail", 1, fail[1], 0);
        cmp("x0_busy", 1, busy[1], 1);
        // randomized runs
        for (int r = 0; r < 20; r++) begin
            do_reset();
            for (int i = 0; i < N; i++) prog(i, $urandom_range(0, 3), $urandom_range(0, 3));
            go($urandom_range(0, 9));
            for (int c = 0; c < 150; c++) begin
                wb_en = 1'($urandom_range(0, 1));
                wb_addr = AW'($urandom_range(0, 3));
                wb_data = DW'($urandom_range(0, 3));
                if ($urandom_range(0, 39) == 0) begin
                    start = 1; cfg_count = 4'($urandom_range(0, 9));
                end
                if ($urandom_range(0, 19) == 0) begin
                    cfg_we = 1; cfg_idx = 3'($urandom_range(0, 7));
                    cfg_addr = AW'($urandom_range(0, 3)); cfg_data = DW'($urandom_range(0, 3));
                end
                rst = $urandom_range(0, 199) != 0;
                cyc();
                rst = 1;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
